// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// Double-buffered BCD word, leading-zero blanking, anode dead-time.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GHOST_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
  logic [4*NUM_DIGITS-1:0] pnd_bcd_q, pnd_bcd_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pnd_dp_q, pnd_dp_d;
  logic                    pend_q, pend_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q;

  logic                    slot_end;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              cur;
  logic                    cur_dp;
  logic                    cur_blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0001000;
      4'd1:    g = 7'b1101101;
      4'd2:    g = 7'b0100010;
      4'd3:    g = 7'b0100100;
      4'd4:    g = 7'b1000101;
      4'd5:    g = 7'b0010100;
      4'd6:    g = 7'b0010000;
      4'd7:    g = 7'b0101101;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign slot_end = (div_cnt_q == DW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the wrap cycle bypasses pending so no frame mixes two words.
  always_comb begin
    act_bcd_d = act_bcd_q;
    act_dp_d  = act_dp_q;
    pnd_bcd_d = pnd_bcd_q;
    pnd_dp_d  = pnd_dp_q;
    pend_d    = pend_q;
    if (load && wrap) begin
      act_bcd_d = bcd_in;
      act_dp_d  = dp_in;
      pend_d    = 1'b0;
    end else if (wrap && pend_q) begin
      act_bcd_d = pnd_bcd_q;
      act_dp_d  = pnd_dp_q;
      pend_d    = 1'b0;
    end else if (load) begin
      pnd_bcd_d = bcd_in;
      pnd_dp_d  = dp_in;
      pend_d    = 1'b1;
    end
  end

  // A digit blanks when it and every digit above it are zero.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_bcd_q[4*k +: 4] == 4'd0);
      blank[k] = zero_run && (k != 0);
    end
  end

  always_comb begin
    cur       = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur       = act_bcd_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_blank = lz_blank && blank[k];
        if (div_cnt_q >= DW'(GHOST_CYC)) begin
          an_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    seg_d = {~cur_dp, glyph(cur)};
    if (cur > 4'd9) begin
      seg_d = 8'b0111_1111;
    end else if (cur_blank) begin
      seg_d[6:0] = 7'b1111111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      act_bcd_q <= '0;
      act_dp_q  <= '0;
      pnd_bcd_q <= '0;
      pnd_dp_q  <= '0;
      pend_q    <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      act_bcd_q <= act_bcd_d;
      act_dp_q  <= act_dp_d;
      pnd_bcd_q <= pnd_bcd_d;
      pnd_dp_q  <= pnd_dp_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= wrap;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-clock slots and
// a 1-clock dead-time; every expected glyph is a hand-written constant.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_cmp;
  int n_err;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GHOST_CYC  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .lz_blank  (lz_blank),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s,
                         input logic [3:0] a, input logic f);
    chk({tag, ".seg"}, {24'd0, seg_n}, {24'd0, s});
    chk({tag, ".an"}, {28'd0, an_n}, {28'd0, a});
    chk({tag, ".fd"}, {31'd0, frame_done}, {31'd0, f});
  endtask

  // Starts with the DUT at div_cnt=0, idx=0 (sampled on a negedge).
  // la/lb: step index at which a load is pulsed (-1 = none).
  task automatic run_frame(input string tag,
                           input logic [7:0] g0, input logic [7:0] g1,
                           input logic [7:0] g2, input logic [7:0] g3,
                           input int la, input logic [15:0] ba,
                           input logic [3:0] da,
                           input int lb, input logic [15:0] bb);
    logic [7:0] g [4];
    logic [3:0] ea;
    int         d;
    int         s;
    g[0] = g0;
    g[1] = g1;
    g[2] = g2;
    g[3] = g3;
    for (int i = 0; i < 16; i++) begin
      load   = (i == la) || (i == lb);
      bcd_in = (i == lb) ? bb : ba;
      dp_in  = (i == la) ? da : 4'd0;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      d    = i / 4;
      s    = i % 4;
      ea   = (s == 0) ? 4'hF : ~(4'b0001 << d);
      chk_out($sformatf("%s[%0d]", tag, i), g[d], ea, i == 15);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    bcd_in   = 16'h0;
    dp_in    = 4'h0;
    lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 8'hFF, 4'hF, 1'b0);
    rst_n = 1'b1;

    run_frame("zeros", 8'h88, 8'h88, 8'h88, 8'h88,
              -1, 16'h0, 4'h0, -1, 16'h0);
    run_frame("midload", 8'h88, 8'h88, 8'h88, 8'h88,
              5, 16'h0042, 4'b0010, -1, 16'h0);
    lz_blank = 1'b1;
    run_frame("x0042", 8'hA2, 8'h45, 8'hFF, 8'hFF,
              3, 16'h1234, 4'h0, 10, 16'h5678);
    run_frame("x5678", 8'h80, 8'hAD, 8'h90, 8'h94,
              15, 16'h9999, 4'h0, -1, 16'h0);
    run_frame("x9999", 8'h84, 8'h84, 8'h84, 8'h84,
              15, 16'h00A0, 4'h0, -1, 16'h0);
    run_frame("x00A0", 8'h88, 8'h7F, 8'hFF, 8'hFF,
              -1, 16'h0, 4'h0, -1, 16'h0);

    load   = 1'b1;
    bcd_in = 16'h1111;
    dp_in  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk_out("preRst0", 8'h88, 4'hF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_out("preRst1", 8'h88, 4'hE, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("asyncRst", 8'hFF, 4'hF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_out("holdRst", 8'hFF, 4'hF, 1'b0);
    rst_n    = 1'b1;
    lz_blank = 1'b0;
    run_frame("post0", 8'h88, 8'h88, 8'h88, 8'h88,
              -1, 16'h0, 4'h0, -1, 16'h0);
    run_frame("post1", 8'h88, 8'h88, 8'h88, 8'h88,
              -1, 16'h0, 4'h0, -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
